// File: rtl/pipe_reg_pkg.sv
// Shared types and helpers for the elastic register pipeline.
package pipe_reg_pkg;

    typedef enum logic [1:0] {
        CMD_RST   = 2'd0,
        CMD_FLUSH = 2'd1,
        CMD_SET   = 2'd2,
        CMD_RUN   = 2'd3
    } cmd_t;

    localparam logic DEF_RST_BIT = 1'b0;
    localparam logic DEF_SET_BIT = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Reset beats flush beats set beats normal advance.
    function automatic cmd_t decode_cmd(input logic rstN, input logic flush, input logic set);
        if (!rstN)
            return CMD_RST;
        else if (flush)
            return CMD_FLUSH;
        else if (set)
            return CMD_SET;
        else
            return CMD_RUN;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a data word plus its valid bit, updated on the falling edge.
module pipe_stage
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DEF_RST_BIT}},
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{DEF_SET_BIT}}
) (
    input  logic             Clk,
    input  logic             RstN,
    input  cmd_t             Cmd,
    input  logic             Load,
    input  logic             VIn,
    input  logic [0:WIDTH-1] DIn,
    output logic             V,
    output logic [0:WIDTH-1] D
);

    // An empty upstream stage only clears V; D keeps its last word.
    always_ff @(negedge Clk or negedge RstN) begin
        if (!RstN) begin
            V <= 1'b0;
            D <= RST_VAL;
        end else begin
            case (Cmd)
                CMD_RST, CMD_FLUSH: begin
                    V <= 1'b0;
                    D <= RST_VAL;
                end
                CMD_SET: begin
                    V <= 1'b1;
                    D <= SET_VAL;
                end
                default: begin
                    if (Load) begin
                        V <= VIn;
                        if (VIn) D <= DIn;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// Elastic valid/ready register pipeline with flush, preset and occupancy count.
module pipe_reg
    import pipe_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DEF_RST_BIT}},
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{DEF_SET_BIT}},
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             Set,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [0:WIDTH-1] DIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [0:WIDTH-1] QOut,
    output logic [CW-1:0]    Count
);

    cmd_t             cmd;
    logic [DEPTH:0]   adv;
    logic [DEPTH-1:0] vq;
    logic [DEPTH-1:0] vin;
    logic [0:WIDTH-1] dq   [DEPTH];
    logic [0:WIDTH-1] dsrc [DEPTH];
    logic [CW-1:0]    popNext;

    assign cmd = decode_cmd(RstN, Flush, Set);

    // Ready ripples from the output back to the input: a stage may load when empty or when its successor moves.
    always_comb begin
        adv = '0;
        adv[DEPTH] = OutReady;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = !vq[i] || adv[i+1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign vin[i]  = InValid;
            assign dsrc[i] = DIn;
        end else begin : g_body
            assign vin[i]  = vq[i-1];
            assign dsrc[i] = dq[i-1];
        end

        pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL),
            .SET_VAL (SET_VAL)
        ) u_stage (
            .Clk  (Clk),
            .RstN (RstN),
            .Cmd  (cmd),
            .Load (adv[i]),
            .VIn  (vin[i]),
            .DIn  (dsrc[i]),
            .V    (vq[i]),
            .D    (dq[i])
        );
    end

    always_comb begin
        popNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            popNext = popNext + CW'(adv[i] ? vin[i] : vq[i]);
        end
    end

    // Count tracks the next valid population so it lands in the same edge as the valid bits.
    always_ff @(negedge Clk or negedge RstN) begin
        if (!RstN) begin
            Count <= '0;
        end else begin
            case (cmd)
                CMD_SET: Count <= CW'(DEPTH);
                CMD_RUN: Count <= popNext;
                default: Count <= '0;
            endcase
        end
    end

    assign InReady  = adv[0];
    assign OutValid = vq[DEPTH-1];
    assign QOut     = dq[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg: a DEPTH=3 instance checked against a word scoreboard, plus a DEPTH=1 corner instance.
module tb_pipe_reg;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       RstN;
    logic       set3, flush3, inV3, oR3, inR3, oV3;
    logic [0:7] din3, q3;
    logic [1:0] cnt3;
    logic       set1, flush1, inV1, oR1, inR1, oV1;
    logic [0:7] din1, q1;
    logic [0:0] cnt1;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb [$];

    pipe_reg #(.WIDTH(8), .DEPTH(3)) u3 (
        .Clk(Clk), .RstN(RstN), .Set(set3), .Flush(flush3),
        .InValid(inV3), .InReady(inR3), .DIn(din3),
        .OutValid(oV3), .OutReady(oR3), .QOut(q3), .Count(cnt3)
    );

    pipe_reg #(.WIDTH(8), .DEPTH(1)) u1 (
        .Clk(Clk), .RstN(RstN), .Set(set1), .Flush(flush1),
        .InValid(inV1), .InReady(inR1), .DIn(din1),
        .OutValid(oV1), .OutReady(oR1), .QOut(q1), .Count(cnt1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the DEPTH=3 instance: drive after the rising edge, score handshakes before the falling edge.
    task automatic applyStimulus(input logic inv, input logic [7:0] din, input logic outr,
                                 input logic flush, input logic set);
        logic acc, emit;
        @(posedge Clk); #1;
        inV3 = inv; din3 = din; oR3 = outr; flush3 = flush; set3 = set;
        #2;
        checkOutput("inready_model", {31'd0, inR3}, {31'd0, (sb.size() < 3) || outr});
        acc  = inv && inR3;
        emit = oV3 && outr;
        if (emit) begin
            if (sb.size() == 0) checkOutput("spurious_out", {31'd0, oV3}, 32'd0);
            else                checkOutput("out_order", {24'd0, q3}, {24'd0, sb.pop_front()});
        end
        if (flush) sb.delete();
        else if (set) begin
            sb.delete();
            repeat (3) sb.push_back(8'hFF);
        end else if (acc) sb.push_back(din);
        @(negedge Clk); #1;
        checkOutput("count_model", {30'd0, cnt3}, sb.size());
    endtask

    initial begin
        RstN = 1'b0;
        set3 = 0; flush3 = 0; inV3 = 0; oR3 = 0; din3 = 8'h00;
        set1 = 0; flush1 = 0; inV1 = 0; oR1 = 0; din1 = 8'h00;

        #3;
        checkOutput("rst_outvalid", {31'd0, oV3}, 32'd0);
        checkOutput("rst_qout", {24'd0, q3}, 32'h00);
        checkOutput("rst_count", {30'd0, cnt3}, 32'd0);
        checkOutput("rst_inready", {31'd0, inR3}, 32'd1);
        #20;
        checkOutput("rst_hold_count", {30'd0, cnt3}, 32'd0);
        checkOutput("rst_hold_outvalid", {31'd0, oV3}, 32'd0);
        @(posedge Clk); #1;
        RstN = 1'b1;
        #1;
        checkOutput("rel_inready", {31'd0, inR3}, 32'd1);

        applyStimulus(1, 8'h11, 1, 0, 0);
        applyStimulus(1, 8'h22, 1, 0, 0);
        applyStimulus(1, 8'h33, 1, 0, 0);
        checkOutput("stream_latency_valid", {31'd0, oV3}, 32'd1);
        checkOutput("stream_latency_q", {24'd0, q3}, 32'h11);
        applyStimulus(1, 8'h44, 1, 0, 0);
        checkOutput("stream_full_count", {30'd0, cnt3}, 32'd3);
        applyStimulus(1, 8'h55, 1, 0, 0);
        checkOutput("stream_full_count2", {30'd0, cnt3}, 32'd3);
        repeat (4) applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("stream_drained", {31'd0, oV3}, 32'd0);

        applyStimulus(1, 8'h11, 0, 0, 0);
        applyStimulus(1, 8'h22, 0, 0, 0);
        applyStimulus(1, 8'h33, 0, 0, 0);
        checkOutput("bp_inready_low", {31'd0, inR3}, 32'd0);
        applyStimulus(1, 8'h44, 0, 0, 0);
        checkOutput("bp_held_q", {24'd0, q3}, 32'h11);
        applyStimulus(1, 8'h44, 1, 0, 0);
        repeat (4) applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("bp_drained", sb.size(), 32'd0);

        applyStimulus(1, 8'h01, 0, 0, 0);
        applyStimulus(1, 8'h02, 0, 0, 0);
        applyStimulus(1, 8'h03, 0, 0, 0);
        applyStimulus(1, 8'hAA, 0, 1, 0);
        checkOutput("flush_count", {30'd0, cnt3}, 32'd0);
        checkOutput("flush_outvalid", {31'd0, oV3}, 32'd0);
        checkOutput("flush_q", {24'd0, q3}, 32'h00);
        repeat (4) applyStimulus(0, 8'h00, 1, 0, 0);

        applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("set_count", {30'd0, cnt3}, 32'd3);
        checkOutput("set_q", {24'd0, q3}, 32'hFF);
        checkOutput("set_outvalid", {31'd0, oV3}, 32'd1);
        applyStimulus(0, 8'h00, 0, 1, 1);
        checkOutput("setflush_count", {30'd0, cnt3}, 32'd0);
        checkOutput("setflush_outvalid", {31'd0, oV3}, 32'd0);
        applyStimulus(0, 8'h00, 0, 0, 1);
        repeat (4) applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("set_drained", sb.size(), 32'd0);

        applyStimulus(1, 8'h77, 1, 0, 0);
        applyStimulus(1, 8'h78, 1, 0, 0);
        @(posedge Clk); #1;
        RstN = 1'b0;
        inV3 = 1'b0;
        #1;
        sb.delete();
        checkOutput("midrst_count", {30'd0, cnt3}, 32'd0);
        checkOutput("midrst_q", {24'd0, q3}, 32'h00);
        @(posedge Clk); #1;
        RstN = 1'b1;
        repeat (3) applyStimulus(0, 8'h00, 1, 0, 0);

        @(posedge Clk); #1;
        inV1 = 1'b1; din1 = 8'h5A; oR1 = 1'b1;
        @(negedge Clk); #1;
        checkOutput("d1_count", {31'd0, cnt1}, 32'd1);
        checkOutput("d1_outvalid", {31'd0, oV1}, 32'd1);
        checkOutput("d1_q", {24'd0, q1}, 32'h5A);
        @(posedge Clk); #1;
        din1 = 8'h6B;
        #2;
        checkOutput("d1_full_inready", {31'd0, inR1}, 32'd1);
        @(negedge Clk); #1;
        checkOutput("d1_full_count", {31'd0, cnt1}, 32'd1);
        checkOutput("d1_full_q", {24'd0, q1}, 32'h6B);
        @(posedge Clk); #1;
        inV1 = 1'b0;
        @(negedge Clk); #1;
        checkOutput("d1_empty_count", {31'd0, cnt1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
